// File: rtl/sprite_pkg.sv
// Shared sprite command definitions used by the arbiter and the sprite controller.
// Holds the op codes, command field positions and the command struct layout.
package sprite_pkg;

    localparam int unsigned CMD_W       = 80;
    localparam int unsigned FIELD_OP_HI = 79;
    localparam int unsigned FIELD_OP_LO = 77;

    typedef enum logic [2:0] {
        SPRITE_NOP  = 3'd0,
        SPRITE_LOAD = 3'd1,
        SPRITE_MOVE = 3'd2,
        SPRITE_WFB  = 3'd3,
        SPRITE_DFB  = 3'd4,
        SPRITE_ATTR = 3'd5,
        SPRITE_PAL  = 3'd6,
        SPRITE_RSV  = 3'd7
    } sprite_op_t;

    typedef struct packed {
        sprite_op_t  op;
        logic [76:0] payload;
    } sprite_command_t;

    localparam sprite_command_t DFB_MARKER = '{op: SPRITE_DFB, payload: '0};

    typedef enum logic {
        ARB_RUN,
        ARB_EMIT
    } arb_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_cmd_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
// Produces a one-hot grant plus the binary index of the winner.
module rr_priority_pick
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0]          grant,
    output logic [idx_w(NUM_REQ)-1:0]   grant_idx,
    output logic                        grant_valid
);

    localparam int unsigned PW = idx_w(NUM_REQ);

    always_comb begin
        int unsigned     j;
        logic [PW-1:0]   jj;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j  = (32'(rr_ptr) + k) % NUM_REQ;
            jj = PW'(j);
            if (!grant_valid && req[jj]) begin
                grant_valid = 1'b1;
                grant[jj]   = 1'b1;
                grant_idx   = jj;
            end
        end
    end

endmodule

// File: rtl/sprite_cmd_arbiter.sv
// Round-robin, credit-flow-controlled arbiter for the sprite command channel.
// Absorbs member DFBs until every frame member has one, then emits a single merged DFB.
module sprite_cmd_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [CMD_W*NUM_REQ-1:0]  req_cmd,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        frame_member,
    input  logic                      sink_consume,
    output logic                      out_produce,
    output logic [CMD_W-1:0]          out_command,
    output logic                      frame_done,
    output logic [15:0]               frame_count,
    output logic [NUM_REQ-1:0]        dfb_pending
);

    localparam int unsigned    PW         = idx_w(NUM_REQ);
    localparam int unsigned    CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(FIFO_DEPTH);

    arb_state_t       state, state_nxt;
    logic [CW-1:0]    credits;
    logic [PW-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] eligible, pick_grant;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic             barrier_done, emit_fire, accept, absorb, load_out;
    sprite_command_t  slice_cmd [NUM_REQ];
    sprite_command_t  granted;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice_cmd[g] = sprite_command_t'(req_cmd[g*CMD_W +: CMD_W]);
    end

    assign eligible     = req_valid & ~dfb_pending;
    assign barrier_done = (|frame_member) && ((dfb_pending & frame_member) == frame_member);

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req         (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (pick_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        emit_fire = 1'b0;
        case (state)
            ARB_RUN: begin
                if (barrier_done) begin
                    state_nxt = ARB_EMIT;
                end else if (pick_valid && (credits != '0) && !rst) begin
                    req_ready = pick_grant;
                end
            end
            ARB_EMIT: begin
                if (credits != '0) begin
                    emit_fire = 1'b1;
                    state_nxt = ARB_RUN;
                end
            end
            default: state_nxt = ARB_RUN;
        endcase
    end

    assign granted  = slice_cmd[pick_idx];
    assign accept   = |req_ready;
    assign absorb   = accept && (granted.op == SPRITE_DFB) && frame_member[pick_idx];
    assign load_out = (accept && !absorb) || emit_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_RUN;
            credits     <= CREDIT_MAX;
            rr_ptr      <= '0;
            dfb_pending <= '0;
            out_produce <= 1'b0;
            out_command <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            out_produce <= load_out;
            frame_done  <= emit_fire;
            if (load_out)
                out_command <= emit_fire ? DFB_MARKER : granted;
            if (emit_fire)
                frame_count <= frame_count + 16'd1;
            if (accept)
                rr_ptr <= (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
            if (emit_fire)
                dfb_pending <= '0;
            else if (absorb)
                dfb_pending[pick_idx] <= 1'b1;
            // Credit is taken when out_produce is loaded, so a back-to-back grant never sees stale space.
            if (load_out && !sink_consume)
                credits <= credits - CW'(1);
            else if (!load_out && sink_consume && (credits != CREDIT_MAX))
                credits <= credits + CW'(1);
        end
    end

endmodule
